// File: rtl/uart_cmd_decoder.sv
// Host-command packet decoder: turns the UART RX byte stream into DATA/CTRL/FREQ/
// PERIOD/REPEAT write strobes with registered payloads, flagging malformed packets.
module uart_cmd_decoder #(
  parameter int          DATA_BIT       = 32,
  parameter int          PACK_NUM       = 4,
  parameter int          OUTPUT_NUM     = 16,
  parameter logic [7:0]  CMD_DATA       = 8'h01,
  parameter logic [7:0]  CMD_CTRL       = 8'h02,
  parameter logic [7:0]  CMD_FREQ       = 8'h03,
  parameter logic [7:0]  CMD_PERIOD     = 8'h04,
  parameter logic [7:0]  CMD_REPEAT     = 8'h05,
  parameter int          TIMEOUT_CYCLES = 200000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    data_i,
  input  logic                          rx_done_tick_i,
  output logic                          data_we_o,
  output logic                          ctrl_we_o,
  output logic                          freq_we_o,
  output logic                          period_we_o,
  output logic                          repeat_we_o,
  output logic [$clog2(OUTPUT_NUM)-1:0] channel_o,
  output logic [DATA_BIT-1:0]           data_o,
  output logic [DATA_BIT-1:0]           freq_o,
  output logic                          idle_o,
  output logic [1:0]                    mode_o,
  output logic                          en_o,
  output logic [7:0]                    slow_period_o,
  output logic [7:0]                    fast_period_o,
  output logic [7:0]                    repeat_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int         CHAN_W  = $clog2(OUTPUT_NUM);
  localparam int         CNT_W   = $clog2(PACK_NUM + 1);
  localparam int         TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0] OUT_LIM = 9'(OUTPUT_NUM);

  typedef enum logic [1:0] {S_IDLE, S_CHAN, S_BODY} state_t;
  typedef enum logic [2:0] {K_DATA, K_CTRL, K_FREQ, K_PERIOD, K_REPEAT} kind_t;

  state_t              state, state_d;
  kind_t               kind, kind_cmd;
  logic                hit;
  logic [CHAN_W-1:0]   chan_q;
  logic                chan_bad;
  logic [CNT_W-1:0]    cnt;
  logic [TO_W-1:0]     tcnt;
  logic                timeout;
  logic                commit;
  logic                err_d;
  logic [DATA_BIT-1:0] shadow;
  logic [DATA_BIT-1:0] shadow_nxt;

  function automatic logic [CNT_W-1:0] last_idx(input kind_t k);
    case (k)
      K_DATA, K_FREQ: return CNT_W'(PACK_NUM - 1);
      K_PERIOD:       return CNT_W'(1);
      default:        return '0;
    endcase
  endfunction

  always_comb begin
    hit      = 1'b1;
    kind_cmd = K_DATA;
    if      (data_i == CMD_DATA)   kind_cmd = K_DATA;
    else if (data_i == CMD_CTRL)   kind_cmd = K_CTRL;
    else if (data_i == CMD_FREQ)   kind_cmd = K_FREQ;
    else if (data_i == CMD_PERIOD) kind_cmd = K_PERIOD;
    else if (data_i == CMD_REPEAT) kind_cmd = K_REPEAT;
    else                           hit      = 1'b0;
  end

  // Payload enters at the top byte so the first byte ends up in bits 7:0.
  assign shadow_nxt = {data_i, shadow[DATA_BIT-1:8]};
  assign timeout    = (state != S_IDLE) && !rx_done_tick_i &&
                      (tcnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign busy_o     = (state != S_IDLE);

  always_comb begin
    state_d = state;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_done_tick_i) begin
          if (hit) state_d = (kind_cmd == K_FREQ || kind_cmd == K_PERIOD) ? S_BODY : S_CHAN;
          else     err_d   = 1'b1;
        end
      end
      S_CHAN: begin
        if (rx_done_tick_i) begin
          state_d = S_BODY;
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_BODY: begin
        if (rx_done_tick_i) begin
          if (cnt == last_idx(kind)) begin
            state_d = S_IDLE;
            if (chan_bad) err_d  = 1'b1;
            else          commit = 1'b1;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (state == S_BODY && rx_done_tick_i) shadow <= shadow_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      kind          <= K_DATA;
      chan_q        <= '0;
      chan_bad      <= 1'b0;
      cnt           <= '0;
      tcnt          <= '0;
      data_we_o     <= 1'b0;
      ctrl_we_o     <= 1'b0;
      freq_we_o     <= 1'b0;
      period_we_o   <= 1'b0;
      repeat_we_o   <= 1'b0;
      err_o         <= 1'b0;
      channel_o     <= '0;
      data_o        <= '0;
      freq_o        <= '0;
      idle_o        <= 1'b0;
      mode_o        <= 2'b00;
      en_o          <= 1'b0;
      slow_period_o <= '0;
      fast_period_o <= '0;
      repeat_o      <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && rx_done_tick_i && hit) begin
        kind     <= kind_cmd;
        chan_bad <= 1'b0;
      end
      if (state == S_CHAN && rx_done_tick_i) begin
        chan_q   <= data_i[CHAN_W-1:0];
        chan_bad <= ({1'b0, data_i} >= OUT_LIM);
      end
      if (state != S_BODY)     cnt <= '0;
      else if (rx_done_tick_i) cnt <= cnt + 1'b1;
      if (rx_done_tick_i || state == S_IDLE || timeout) tcnt <= '0;
      else                                              tcnt <= tcnt + 1'b1;

      data_we_o   <= commit && (kind == K_DATA);
      ctrl_we_o   <= commit && (kind == K_CTRL);
      freq_we_o   <= commit && (kind == K_FREQ);
      period_we_o <= commit && (kind == K_PERIOD);
      repeat_we_o <= commit && (kind == K_REPEAT);
      err_o       <= err_d;

      if (commit) begin
        case (kind)
          K_DATA: begin
            data_o    <= shadow_nxt;
            channel_o <= chan_q;
          end
          K_CTRL: begin
            idle_o    <= data_i[3];
            mode_o    <= data_i[2:1];
            en_o      <= data_i[0];
            channel_o <= chan_q;
          end
          K_FREQ: freq_o <= shadow_nxt;
          K_PERIOD: begin
            slow_period_o <= shadow_nxt[DATA_BIT-9 -: 8];
            fast_period_o <= shadow_nxt[DATA_BIT-1 -: 8];
          end
          K_REPEAT: begin
            repeat_o  <= data_i;
            channel_o <= chan_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: directed packets from the test plan plus
// random packet streams, each compared as a full output snapshot per strobe/error.
module tb_uart_cmd_decoder;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        tick = 1'b0;
  logic        data_we, ctrl_we, freq_we, period_we, repeat_we;
  logic [3:0]  channel;
  logic [31:0] data_v, freq_v;
  logic        idle_v, en_v, busy, err;
  logic [1:0]  mode_v;
  logic [7:0]  slow_v, fast_v, rpt_v;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din), .rx_done_tick_i(tick),
    .data_we_o(data_we), .ctrl_we_o(ctrl_we), .freq_we_o(freq_we),
    .period_we_o(period_we), .repeat_we_o(repeat_we), .channel_o(channel),
    .data_o(data_v), .freq_o(freq_v), .idle_o(idle_v), .mode_o(mode_v),
    .en_o(en_v), .slow_period_o(slow_v), .fast_period_o(fast_v),
    .repeat_o(rpt_v), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // we = {repeat, period, freq, ctrl, data}
  typedef struct packed {
    logic [4:0]  we;
    logic        err;
    logic [3:0]  ch;
    logic [31:0] data;
    logic [31:0] freq;
    logic        idle;
    logic [1:0]  mode;
    logic        en;
    logic [7:0]  slow;
    logic [7:0]  fast;
    logic [7:0]  rpt;
  } snap_t;

  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];
  snap_t model = '0;

  function automatic snap_t dut_snap();
    snap_t s;
    s.we   = {repeat_we, period_we, freq_we, ctrl_we, data_we};
    s.err  = err;
    s.ch   = channel;
    s.data = data_v;
    s.freq = freq_v;
    s.idle = idle_v;
    s.mode = mode_v;
    s.en   = en_v;
    s.slow = slow_v;
    s.fast = fast_v;
    s.rpt  = rpt_v;
    return s;
  endfunction

  always @(negedge clk) begin : monitor
    snap_t a, e;
    if (rst_n) begin
      a = dut_snap();
      if (a.we != 5'b0 || a.err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event act=%h req=none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL event act=%h req=%h", a, e);
          end
        end
      end
    end
  end

  task automatic push(input logic [4:0] we, input logic e);
    snap_t s;
    s     = model;
    s.we  = we;
    s.err = e;
    exp_q.push_back(s);
  endtask

  function automatic int g();
    return int'($urandom_range(1, 4));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    din  = b;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    din  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_data(input logic [7:0] ch, input logic [31:0] d);
    if (ch >= 8'd16) push(5'b0, 1'b1);
    else begin
      model.ch   = ch[3:0];
      model.data = d;
      push(5'b00001, 1'b0);
    end
    send_byte(8'h01, g());
    send_byte(ch, g());
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], g());
  endtask

  task automatic do_ctrl(input logic [7:0] ch, input logic [7:0] c);
    if (ch >= 8'd16) push(5'b0, 1'b1);
    else begin
      model.ch   = ch[3:0];
      model.idle = c[3];
      model.mode = c[2:1];
      model.en   = c[0];
      push(5'b00010, 1'b0);
    end
    send_byte(8'h02, g());
    send_byte(ch, g());
    send_byte(c, g());
  endtask

  task automatic do_freq(input logic [31:0] f);
    model.freq = f;
    push(5'b00100, 1'b0);
    send_byte(8'h03, g());
    for (int i = 0; i < 4; i++) send_byte(f[8*i +: 8], g());
  endtask

  task automatic do_period(input logic [7:0] s, input logic [7:0] f);
    model.slow = s;
    model.fast = f;
    push(5'b01000, 1'b0);
    send_byte(8'h04, g());
    send_byte(s, g());
    send_byte(f, g());
  endtask

  task automatic do_repeat(input logic [7:0] ch, input logic [7:0] r);
    if (ch >= 8'd16) push(5'b0, 1'b1);
    else begin
      model.ch  = ch[3:0];
      model.rpt = r;
      push(5'b10000, 1'b0);
    end
    send_byte(8'h05, g());
    send_byte(ch, g());
    send_byte(r, g());
  endtask

  task automatic do_unknown(input logic [7:0] b);
    push(5'b0, 1'b1);
    send_byte(b, g());
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%b req=%b", name, act, req);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    snap_t a;
    a = dut_snap();
    checks++;
    if (a !== snap_t'(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s act=%h busy=%b req=0", name, a, busy);
    end
  endtask

  initial begin
    logic [7:0] ch, b;
    int         k;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("after_reset_release");

    do_freq(32'h5555_5555);
    do_freq(32'h1234_5678);
    do_period(8'h14, 8'h05);
    do_repeat(8'h0F, 8'h03);
    do_data(8'h01, 32'h5555_5555);
    do_ctrl(8'h01, 8'h04);
    do_ctrl(8'h01, 8'h0B);
    do_ctrl(8'h03, 8'hF6);
    do_unknown(8'hFF);
    do_period(8'hA0, 8'h3C);
    do_ctrl(8'h10, 8'h07);

    // Inter-byte timeout after two payload bytes of a DATA packet
    push(5'b0, 1'b1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    check_bit("busy_mid_packet", busy, 1'b1);
    repeat (TO + 10) @(negedge clk);
    check_bit("busy_after_timeout", busy, 1'b0);
    do_data(8'h02, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a DATA packet
    repeat (5) @(negedge clk);
    send_byte(8'h01, 1);
    send_byte(8'h03, 1);
    send_byte(8'h11, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset_mid_packet");
    model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_period(8'h22, 8'h33);

    for (int n = 0; n < 250; n++) begin
      k  = int'($urandom_range(0, 5));
      ch = 8'($urandom_range(0, 19));
      case (k)
        0: do_data(ch, 32'($urandom));
        1: do_ctrl(ch, 8'($urandom));
        2: do_freq(32'($urandom));
        3: do_period(8'($urandom), 8'($urandom));
        4: do_repeat(ch, 8'($urandom));
        default: begin
          b = 8'($urandom_range(6, 255));
          do_unknown(b);
        end
      endcase
    end

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events act=%0d req=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
